// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding and the parameter sanity check.
package seq_mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic bit widths_ok(input int width, input int out_width);
    return (width >= 2) && (out_width >= 2 * width);
  endfunction

endpackage

// File: rtl/mult_abs_neg.sv
// Combinational conditional two's-complement negate: either magnitude of a
// signed value (take_abs) or an explicit sign flip (negate).
module mult_abs_neg #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic         take_abs,
  input  logic         negate,
  output logic [W-1:0] y
);

  logic flip;

  // |-2^(W-1)| wraps back to the same bit pattern, which is the correct
  // unsigned magnitude, so no extra width is needed.
  always_comb begin
    flip = take_abs ? x[W-1] : negate;
    y    = flip ? (~x + W'(1)) : x;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier with valid/ready handshakes,
// per-transaction signed mode and optional early exit on zero multiplier.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// BUSY    | one shift-add iteration per clock
// DONE    | product held in oval until out_ready
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OUT_WIDTH  = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     lop,
  input  logic [WIDTH-1:0]     rop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] oval,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  if (!widths_ok(WIDTH, OUT_WIDTH)) begin : g_bad_width
    $error("seq_multiplier: need WIDTH >= 2 and OUT_WIDTH >= 2*WIDTH");
  end

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [PW-1:0]        mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 neg_q, neg_d;
  logic [OUT_WIDTH-1:0] oval_q, oval_d;

  logic [WIDTH-1:0]     lop_mag, rop_mag, mplier_shift;
  logic [PW-1:0]        acc_sum;
  logic [OUT_WIDTH-1:0] res_val;
  logic                 finish;

  mult_abs_neg #(.W(WIDTH)) u_lop_abs (
    .x(lop), .take_abs(signed_mode), .negate(1'b0), .y(lop_mag)
  );

  mult_abs_neg #(.W(WIDTH)) u_rop_abs (
    .x(rop), .take_abs(signed_mode), .negate(1'b0), .y(rop_mag)
  );

  mult_abs_neg #(.W(OUT_WIDTH)) u_res_neg (
    .x(OUT_WIDTH'(acc_sum)), .take_abs(1'b0), .negate(neg_q), .y(res_val)
  );

  assign acc_sum      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_shift = mplier_q >> 1;
  assign finish       = (count_q == CW'(WIDTH - 1)) ||
                        (EARLY_EXIT && (mplier_shift == '0));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    oval_d   = oval_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d  = PW'(lop_mag);
          mplier_d = rop_mag;
          neg_d    = signed_mode & (lop[WIDTH-1] ^ rop[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        count_d  = count_q + CW'(1);
        if (finish) begin
          oval_d  = res_val;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      oval_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      oval_q   <= oval_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_BUSY);
  assign out_valid = (state_q == ST_DONE);
  assign oval      = oval_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: dut0 runs full WIDTH iterations,
// dut1 uses early exit. Expected product, latency and hold time are queued at issue.
module tb_seq_multiplier;

  typedef struct {
    logic [31:0] val;
    int          lat;
    int          hold;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  reset, in_valid, in_ready, out_ready, out_valid, busy;
  logic        signed_mode;
  logic [7:0]  lop, rop;
  logic [31:0] oval_a [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        cur[2];
  int          accept_cyc[2];
  int          hold[2];
  bit          presented[2];
  bit          post_retire[2];
  logic [31:0] held_val[2];

  always @(posedge clk) cyc++;

  seq_multiplier #(.WIDTH(8), .OUT_WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .reset(reset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .signed_mode(signed_mode), .lop(lop), .rop(rop), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .oval(oval_a[0]), .busy(busy[0])
  );

  seq_multiplier #(.WIDTH(8), .OUT_WIDTH(32), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .reset(reset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .signed_mode(signed_mode), .lop(lop), .rop(rop), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .oval(oval_a[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no response, required one", name);
  endtask

  // Monitor: compares whenever a DUT presents a product.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (reset[s]) begin
        presented[s]   = 1'b0;
        post_retire[s] = 1'b0;
        hold[s]        = 0;
      end else begin
        if (post_retire[s]) begin
          check($sformatf("d%0d_in_ready_after_retire", s), 32'(in_ready[s]), 32'd1);
          check($sformatf("d%0d_out_valid_after_retire", s), 32'(out_valid[s]), 32'd0);
          post_retire[s] = 1'b0;
        end
        if (out_valid[s]) begin
          if (!presented[s]) begin
            if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
              n_tests++;
              n_fail++;
              $display("FAIL d%0d_unexpected_output: got 0x%0h, required no output", s, oval_a[s]);
            end else begin
              if (s == 0) cur[0] = q0.pop_front();
              else        cur[1] = q1.pop_front();
              check($sformatf("d%0d_oval", s), oval_a[s], cur[s].val);
              check($sformatf("d%0d_latency", s), 32'(cyc - accept_cyc[s]), 32'(cur[s].lat));
              check($sformatf("d%0d_busy_in_done", s), 32'(busy[s]), 32'd0);
            end
            presented[s] = 1'b1;
            held_val[s]  = oval_a[s];
            hold[s]      = 0;
          end else begin
            check($sformatf("d%0d_oval_stable", s), oval_a[s], held_val[s]);
          end
          check($sformatf("d%0d_in_ready_in_done", s), 32'(in_ready[s]), 32'd0);
          if (!out_ready[s]) begin
            hold[s]++;
          end else begin
            check($sformatf("d%0d_hold_cycles", s), 32'(hold[s]), 32'(cur[s].hold));
            presented[s]   = 1'b0;
            post_retire[s] = 1'b1;
          end
        end
      end
    end
  end

  // Called in the posedge+#1 phase; returns just after the accept edge.
  task automatic issue(input int s, input bit sm, input logic [7:0] l, input logic [7:0] r,
                       input logic [31:0] v, input int lat, input int hld);
    exp_t e;
    int   guard = 0;
    e.val  = v;
    e.lat  = lat;
    e.hold = hld;
    while (!in_ready[s] && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready[s]) begin
      fail_now($sformatf("d%0d_accept_timeout", s));
      return;
    end
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
    signed_mode = sm;
    lop         = l;
    rop         = r;
    in_valid[s] = 1'b1;
    @(posedge clk); #1;
    in_valid[s]   = 1'b0;
    accept_cyc[s] = cyc;
  endtask

  task automatic wait_drain(input int s);
    int guard = 0;
    while ((((s == 0) ? q0.size() : q1.size()) != 0 || presented[s] || post_retire[s])
           && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) fail_now($sformatf("d%0d_drain_timeout", s));
  endtask

  initial begin
    int guard;
    reset       = 2'b11;
    in_valid    = 2'b00;
    out_ready   = 2'b11;
    signed_mode = 1'b0;
    lop         = '0;
    rop         = '0;
    repeat (3) @(posedge clk);
    #1 reset = 2'b00;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("d%0d_rst_in_ready", s), 32'(in_ready[s]), 32'd1);
      check($sformatf("d%0d_rst_busy", s), 32'(busy[s]), 32'd0);
      check($sformatf("d%0d_rst_out_valid", s), 32'(out_valid[s]), 32'd0);
      check($sformatf("d%0d_rst_oval", s), oval_a[s], 32'd0);
    end
    @(posedge clk); #1;

    // Full-length unsigned products, including back-to-back issue.
    issue(0, 1'b0, 8'd5, 8'd3, 32'd15, 8, 0);
    wait_drain(0);
    issue(0, 1'b0, 8'd45, 8'd13, 32'd585, 8, 0);
    issue(0, 1'b0, 8'd20, 8'd5, 32'd100, 8, 0);
    wait_drain(0);

    // Signed and extreme operands.
    issue(0, 1'b1, 8'hEC, 8'd5, 32'hFFFF_FF9C, 8, 0);
    issue(0, 1'b1, 8'h80, 8'h80, 32'h0000_4000, 8, 0);
    issue(0, 1'b0, 8'hFF, 8'hFF, 32'h0000_FE01, 8, 0);
    wait_drain(0);

    // Early exit: latency follows the top set bit of |rop|.
    issue(1, 1'b0, 8'd5, 8'd3, 32'd15, 2, 0);
    issue(1, 1'b0, 8'd5, 8'd0, 32'd0, 1, 0);
    issue(1, 1'b0, 8'd5, 8'h80, 32'd640, 8, 0);
    issue(1, 1'b1, 8'd7, 8'hFF, 32'hFFFF_FFF9, 1, 0);
    issue(1, 1'b1, 8'h83, 8'd2, 32'hFFFF_FF06, 2, 0);
    wait_drain(1);

    // Backpressure: product held for three cycles before acceptance.
    out_ready[0] = 1'b0;
    issue(0, 1'b0, 8'd7, 8'd9, 32'd63, 8, 3);
    guard = 0;
    while (!out_valid[0] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!out_valid[0]) fail_now("d0_backpressure_wait");
    repeat (3) @(posedge clk);
    #1 out_ready[0] = 1'b1;
    wait_drain(0);

    // Abort in the middle of BUSY.
    guard = 0;
    while (!in_ready[0] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    signed_mode = 1'b0;
    lop         = 8'd9;
    rop         = 8'd11;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("d0_busy_before_abort", 32'(busy[0]), 32'd1);
    reset[0] = 1'b1;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    check("d0_abort_out_valid", 32'(out_valid[0]), 32'd0);
    check("d0_abort_oval", oval_a[0], 32'd0);
    check("d0_abort_in_ready", 32'(in_ready[0]), 32'd1);
    check("d0_abort_busy", 32'(busy[0]), 32'd0);
    issue(0, 1'b0, 8'd6, 8'd7, 32'd42, 8, 0);
    wait_drain(0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised, iterative radix-2 shift-add multiplier. It is the sequential successor to the 8-bit combinational multiplier used in the processing elements.
- Adds configurable operand width and per-transaction signed/unsigned mode.
- Adds valid/ready handshakes on input and output.
- Adds optional zero-skip early termination, so latency scales with the magnitude of the right operand.
- Sits between the PE operand registers and the accumulator, where multiplier area matters more than latency.

Parameters:
WIDTH, 8, operand width in bits (≥2).
OUT_WIDTH, 32, result width; must be ≥ 2*WIDTH; the product is sign/zero-extended to this width.
EARLY_EXIT, 1, when 1, finish as soon as the remaining multiplier bits are all zero; when 0, always run WIDTH iterations.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operands and mode are valid.
in_ready  output  1  block can accept operands (high only in IDLE).
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured on accept.
lop  input  WIDTH  left operand (multiplicand).
rop  input  WIDTH  right operand (multiplier).
out_valid  output  1  oval holds a completed product.
out_ready  input  1  consumer accepts oval.
oval  output  OUT_WIDTH  product, registered.
busy  output  1  high in BUSY.

Behaviour:
- Reset (sync, active-high, on posedge):
  - state=IDLE; out_valid=0; oval=0; busy=0; in_ready=1 on the following cycle.
  - All internal registers (acc, mcand, mplier, count, neg) are cleared.
- States are IDLE, BUSY, DONE. Outputs decode from the state register: in_ready=(IDLE), busy=(BUSY), out_valid=(DONE).
- IDLE: on posedge with in_valid && in_ready (edge T):
  - signed_mode=1: mcand←|lop|, mplier←|rop|, neg←sign(lop)^sign(rop).
  - signed_mode=0: raw operands, neg←0.
  - acc←0, count←0, go to BUSY.
  - |−2^(WIDTH-1)| = 2^(WIDTH-1) must be held correctly, so magnitudes are unsigned WIDTH bits.
- BUSY, one iteration per edge:
  - If mplier[0], acc←acc+mcand, where acc is 2*WIDTH bits and mcand is left-shifted 2*WIDTH bits.
  - Then mcand←mcand<<1, mplier←mplier>>1, count←count+1.
  - Finish condition: count+1==WIDTH, or EARLY_EXIT=1 and (mplier>>1)==0.
  - On finish at the same edge: oval←neg ? −ext(acc_next) : ext(acc_next), with ext = zero-extension to OUT_WIDTH before negation. Go to DONE.
- Latency, from accept edge T to the out_valid=1 edge:
  - EARLY_EXIT=0: exactly WIDTH cycles.
  - EARLY_EXIT=1: max(1, position of the highest set bit of |rop| + 1). rop=0 gives 1 cycle.
- DONE:
  - oval and out_valid held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE, out_valid←0 at that edge, in_ready=1 the next cycle. oval keeps its value; it is only meaningful when out_valid=1.
- No input acceptance in BUSY or DONE. in_valid there is ignored and operands must be held by the producer.
- Accepting new input in the same cycle as output retirement is not supported: throughput is one product per latency+2 cycles minimum.
- reset asserted in BUSY or DONE aborts the operation. The result is discarded, no out_valid pulse, IDLE next cycle.
- Unsigned results never exceed 2*WIDTH bits. The signed result range −2^(2W-2)+2^(W-1) .. 2^(2W-2) fits, so no overflow is possible.

Decomposition:
- Shared package seq_mult_pkg: state encoding localparams (ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2) and a width-check function.
- Elaboration-time error if OUT_WIDTH < 2*WIDTH or WIDTH < 2.
- One natural sub-module, mult_abs_neg: combinational abs-with-sign-flag for operands plus a conditional OUT_WIDTH negate. Instantiated for lop, rop and the result.
- The FSM and shift-add datapath stay in seq_multiplier.

Test Plan:
1. WIDTH=8, EARLY_EXIT=0, unsigned lop=5, rop=3, out_ready=1 -> out_valid exactly 8 cycles after accept, oval=15, then in_ready=1 one cycle after retirement.
2. Unsigned lop=45, rop=13, then lop=20, rop=5, back-to-back -> oval=585, then 100. in_ready=0 throughout BUSY/DONE; the second accept happens only after the first retires.
3. Signed lop=8'hEC (−20), rop=5 -> oval=32'hFFFF_FF9C. Signed −128×−128 -> 32'h0000_4000. Unsigned 255×255 -> 32'h0000_FE01.
4. EARLY_EXIT=1: rop=3 -> latency 2; rop=0 -> latency 1, oval=0; rop=8'h80 unsigned -> latency 8. Products match case 1.
5. Backpressure: complete 7×9 with out_ready=0 for 3 cycles -> oval=63 and out_valid=1 stable for 3 cycles, in_ready=0; retires on the first cycle out_ready=1.
6. Assert reset for one cycle at iteration 4 of BUSY -> next cycle out_valid=0, oval=0, in_ready=1, busy=0. A following 6×7 yields 42 with normal latency.
